// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op encodings, FSM states and the
// single-cycle result/carry function.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_RSVD = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_ADDU = 4'b1000;
  localparam logic [3:0] ALU_SUBU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_LUI  = 4'b1110;
  localparam logic [3:0] ALU_MUL  = 4'b1111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MBUSY = 1'b1
  } state_t;

  // The function works on a fixed wide container; callers zero-extend their
  // N-bit operands and pass N so the result is masked back to N bits.
  localparam int ALU_MAX_W = 128;
  localparam int ALU_SH_W  = $clog2(ALU_MAX_W);
  localparam int ALU_CP_W  = ALU_SH_W + 1;

  function automatic logic [ALU_MAX_W:0] alu_single(
    input logic [3:0]           op,
    input logic [ALU_MAX_W-1:0] a,
    input logic [ALU_MAX_W-1:0] b,
    input logic [ALU_SH_W-1:0]  shamt,
    input int                   n
  );
    logic [ALU_MAX_W-1:0]        mask;
    logic [ALU_MAX_W-1:0]        sx_a;
    logic [ALU_MAX_W-1:0]        sx_b;
    logic [ALU_MAX_W-1:0]        w;
    logic signed [ALU_MAX_W-1:0] sra;
    logic [ALU_MAX_W:0]          sum;
    logic [ALU_SH_W-1:0]         msb;
    logic [ALU_CP_W-1:0]         cpos;
    logic                        c;
    mask = {ALU_MAX_W{1'b1}} >> (ALU_MAX_W - n);
    msb  = ALU_SH_W'(n - 1);
    cpos = ALU_CP_W'(n);
    sx_a = a[msb] ? (a | ~mask) : a;
    sx_b = b[msb] ? (b | ~mask) : b;
    sra  = $signed(sx_a) >>> shamt;
    sum  = '0;
    w    = '0;
    c    = 1'b0;
    case (op)
      ALU_AND: w = a & b;
      ALU_OR:  w = a | b;
      ALU_XOR: w = a ^ b;
      ALU_NOR: w = ~(a | b) & mask;
      ALU_ADD, ALU_ADDU: begin
        sum = {1'b0, a} + {1'b0, b};
        w   = sum[ALU_MAX_W-1:0] & mask;
        c   = sum[cpos];
      end
      // Subtraction as A + ~B + 1 so the carry out is the inverted borrow.
      ALU_SUB, ALU_SUBU: begin
        sum = {1'b0, a} + {1'b0, ~b & mask} + ALU_CP_W'(1);
        w   = sum[ALU_MAX_W-1:0] & mask;
        c   = sum[cpos];
      end
      ALU_SLL:  w = (a << shamt) & mask;
      ALU_SRL:  w = a >> shamt;
      ALU_SRA:  w = sra & mask;
      ALU_SLT:  w = ($signed(sx_a) < $signed(sx_b)) ? ALU_MAX_W'(1) : '0;
      ALU_SLTU: w = (a < b) ? ALU_MAX_W'(1) : '0;
      ALU_LUI:  w = (b & (mask >> (n / 2))) << (n / 2);
      default:  w = '0;
    endcase
    return {c, w};
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, done is
// asserted combinationally on the last iteration with the final product.
module alu_mul_seq #(
  parameter  int N  = 32,
  localparam int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] result
);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [N-1:0]  mcand_p1;
  logic [N-1:0]  mplier_p1;
  logic [N-1:0]  acc_p1;
  logic [N-1:0]  acc_nxt;

  assign acc_nxt = mplier_p1[0] ? (acc_p1 + mcand_p1) : acc_p1;
  assign done    = busy && (cnt == CW'(N - 1));
  assign result  = acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

  // ---- iteration datapath (no reset needed; loaded on start) ----
  always_ff @(posedge clk) begin
    if (start) begin
      mcand_p1  <= a;
      mplier_p1 <= b;
      acc_p1    <= '0;
    end else if (busy) begin
      acc_p1    <= acc_nxt;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides; single-cycle ops
// return after one edge, MUL after N edges via the sequential multiplier.
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int N   = 32,
  localparam int SHW = $clog2(N)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [N-1:0] BusA,
  input  logic [N-1:0] BusB,
  input  logic [3:0]   ALUCtrl,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] BusW,
  output logic         Zero,
  output logic         Neg,
  output logic         Ovf,
  output logic         Cout
);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [N-1:0]       mul_res;
  logic [ALU_MAX_W:0] core;
  logic [N-1:0]       w_c;
  logic               cout_c;
  logic               ovf_c;
  logic               zero_c;
  logic               core_unused;

  logic               vld_p1;
  logic [N-1:0]       w_p1;
  logic               zero_p1;
  logic               neg_p1;
  logic               ovf_p1;
  logic               cout_p1;

  assign accept = InValid && InReady;
  assign is_mul = (ALUCtrl == ALU_MUL);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && is_mul) state_nxt = ST_MBUSY;
      ST_MBUSY: if (mul_done)         state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A new op may only enter when the output slot is free or retiring now.
  always_comb begin
    InReady = (state == ST_IDLE) && (!vld_p1 || OutReady);
  end

  assign core        = alu_single(ALUCtrl, ALU_MAX_W'(BusA), ALU_MAX_W'(BusB),
                                  ALU_SH_W'(BusB[SHW-1:0]), N);
  assign w_c         = core[N-1:0];
  assign cout_c      = core[ALU_MAX_W];
  assign core_unused = ^core[ALU_MAX_W-1:N];
  assign zero_c      = (ALUCtrl != ALU_RSVD) && (w_c == '0);

  always_comb begin
    case (ALUCtrl)
      ALU_ADD: ovf_c = (BusA[N-1] == BusB[N-1]) && (w_c[N-1] != BusA[N-1]);
      ALU_SUB: ovf_c = (BusA[N-1] != BusB[N-1]) && (w_c[N-1] != BusA[N-1]);
      default: ovf_c = 1'b0;
    endcase
  end

  alu_mul_seq #(.N(N)) u_mul (
    .clk    (Clk),
    .rst    (Reset),
    .start  (accept && is_mul),
    .a      (BusA),
    .b      (BusB),
    .done   (mul_done),
    .result (mul_res)
  );

  // ---- output register stage ----
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p1  <= 1'b0;
      w_p1    <= '0;
      zero_p1 <= 1'b0;
      neg_p1  <= 1'b0;
      ovf_p1  <= 1'b0;
      cout_p1 <= 1'b0;
    end else if (accept && !is_mul) begin
      vld_p1  <= 1'b1;
      w_p1    <= w_c;
      zero_p1 <= zero_c;
      neg_p1  <= w_c[N-1];
      ovf_p1  <= ovf_c;
      cout_p1 <= cout_c;
    end else if (accept) begin
      // MUL accepted: any previous result is retiring on this same edge.
      vld_p1 <= 1'b0;
    end else if (mul_done) begin
      vld_p1  <= 1'b1;
      w_p1    <= mul_res;
      zero_p1 <= (mul_res == '0);
      neg_p1  <= mul_res[N-1];
      ovf_p1  <= 1'b0;
      cout_p1 <= 1'b0;
    end else if (OutReady) begin
      vld_p1 <= 1'b0;
    end
  end

  assign OutValid = vld_p1;
  assign BusW     = w_p1;
  assign Zero     = zero_p1;
  assign Neg      = neg_p1;
  assign Ovf      = ovf_p1;
  assign Cout     = cout_p1;

endmodule
